arb4_rr: RTL and testbench
==========================

# arb4_rr

Four-requester round-robin arbiter that shares one downstream resource (e.g. a 4-to-2 encoder datapath or shared bus slot) between four agents. It registers a one-hot grant and its 2-bit binary index with a valid flag. Each grant is held until the owner releases it, drops its request, or exceeds a hold limit. It sits between requesting agents and the shared resource and owns all sequencing of access to that resource.

## Interface
- HOLD_MAX, 8, maximum consecutive cycles one owner may hold the grant; legal range 1..255.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  arbiter enable; 0 forces idle, no grants.
- req  input  4  request per agent, bit i = agent i; level-sensitive.
- done  input  1  release strobe from current owner; ignored when no grant is active.
- gnt  output  4  registered one-hot grant; 4'b0000 when no grant.
- gnt_id  output  2  registered binary index of owner (0..3); 2'b00 when gnt_valid=0 (never x/z).
- gnt_valid  output  1  1 while a grant is active.
- timeout  output  1  one-cycle pulse on the edge where a grant is revoked by the hold limit.

## Operation
- Reset state: state=IDLE, gnt=0000, gnt_id=00, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0.
- ptr (2 bits) marks the highest-priority agent. Search order: ptr, ptr+1, ptr+2, ptr+3, mod 4.
- IDLE:
  - If en=1 and req!=0, grant the first requester in search order.
  - On that edge: gnt=onehot(w), gnt_id=w, gnt_valid=1, hold_cnt=1, state=GRANT.
  - Otherwise remain in IDLE with outputs at their reset values.
- GRANT (owner w). The grant ends on an edge if any of the following holds:
  - en=0;
  - done=1;
  - req[w]=0;
  - hold_cnt==HOLD_MAX.
- On a release edge: state=IDLE, gnt=0000, gnt_id=00, gnt_valid=0, ptr=w+1 (2-bit wrap, 3 goes to 0).
  - timeout=1 for that one cycle only when the hold limit is the sole cause. If done, req drop or en=0 coincides with the limit, timeout stays 0.
- Otherwise remain in GRANT and increment hold_cnt (saturating at HOLD_MAX).
- en=0 in IDLE: no grant is issued and ptr is unchanged.
- Requests from non-owners during GRANT are ignored and never preempt the owner.
- hold_cnt width is 8 bits. Comparisons are unsigned.
- Asynchronous rst mid-grant: outputs return to reset values immediately, without waiting for a clock edge. The first arbitration after reset starts from ptr=0.

## Timing
- Request to grant: 1 cycle. req is sampled at edge N and gnt is visible after edge N.
- Release to grant removal: 1 cycle. done sampled at edge N, gnt=0 after edge N.
- One mandatory IDLE bubble between consecutive grants. Next grant earliest at edge N+1.
- Maximum grant duration: exactly HOLD_MAX cycles with gnt_valid=1.
- Worst-case wait for a continuously requesting agent: 3*(HOLD_MAX+1) cycles after its first sampled request.
- gnt, gnt_id and gnt_valid always change on the same edge and are mutually consistent.

## Test plan
- Reset/idle:
  - Assert rst with req=1111 → gnt=0000, gnt_id=00, gnt_valid=0, timeout=0.
  - Release rst with req=0000 → outputs stay at reset values.
- Round-robin rotation:
  - en=1, req=1111, pulse done 2 cycles after each grant → grant order 0,1,2,3,0.
  - gnt_id follows 00,01,10,11,00, with one gnt_valid=0 cycle between grants.
- Hold limit:
  - HOLD_MAX=4, req=0011, done never asserted.
  - Expect agent 0 granted for exactly 4 cycles, timeout=1 on the revoke edge, 1 idle cycle, then agent 1 granted.
- Request drop and wrap:
  - Agent 3 granted, then req[3] falls → gnt=0000 next edge, timeout=0.
  - Then with req=1001 → agent 0 granted (ptr wrapped to 0).
- Enable and done gating:
  - en=0 with req=0100 → no grant.
  - Raise en → gnt=0100 after 1 edge.
  - Drop en mid-grant → gnt=0000 next edge.
  - done=1 while idle → no state change.
- Async reset mid-grant:
  - While gnt=0010, assert rst between clock edges → outputs clear immediately.
  - After release with req=1111 → agent 0 granted first.

Source files
------------

// File: rtl/arb4_rr.sv
// arb4_rr: four-requester round-robin arbiter with a per-grant hold limit.
// Ports: clk, rst (async, active-high), en, req[3:0], done in;
//        gnt[3:0] one-hot, gnt_id[1:0], gnt_valid, timeout pulse out.
module arb4_rr #(
   parameter int HOLD_MAX = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       gnt_valid,
   output logic       timeout
);

   localparam logic [7:0] HMAX = 8'(HOLD_MAX);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     state;
   state_t     state_n;
   logic [1:0] ptr;
   logic [1:0] ptr_n;
   logic [7:0] hold_cnt;
   logic [7:0] hold_n;
   logic [3:0] gnt_n;
   logic [1:0] id_n;
   logic       valid_n;
   logic       tmo_n;

   logic [1:0] win;
   logic [1:0] idx;
   logic       any;
   logic       own_req;
   logic       at_lim;
   logic       rel;
   logic       lim_only;

   // Walk the search order backwards so the lowest offset from ptr
   // (the highest-priority requester) is the last one written.
   always_comb begin
      win = ptr;
      idx = ptr;
      any = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (req[idx]) begin
            win = idx;
            any = 1'b1;
         end
      end
   end

   assign own_req = req[gnt_id];
   assign at_lim  = (hold_cnt >= HMAX);
   assign rel     = !en || done || !own_req || at_lim;

   // timeout only flags a revoke that nothing else would have caused.
   assign lim_only = at_lim && en && !done && own_req;

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      hold_n  = hold_cnt;
      gnt_n   = gnt;
      id_n    = gnt_id;
      valid_n = gnt_valid;
      tmo_n   = 1'b0;
      case (state)
         IDLE: begin
            if (en && any) begin
               state_n = GRANT;
               gnt_n   = 4'b0001 << win;
               id_n    = win;
               valid_n = 1'b1;
               hold_n  = 8'd1;
            end
         end
         GRANT: begin
            if (rel) begin
               state_n = IDLE;
               gnt_n   = 4'b0000;
               id_n    = 2'b00;
               valid_n = 1'b0;
               hold_n  = 8'd0;
               ptr_n   = gnt_id + 2'd1;
               tmo_n   = lim_only;
            end else if (hold_cnt < HMAX) begin
               hold_n = hold_cnt + 8'd1;
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
            id_n    = 2'b00;
            valid_n = 1'b0;
            hold_n  = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 2'd0;
         hold_cnt  <= 8'd0;
         gnt       <= 4'b0000;
         gnt_id    <= 2'b00;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         hold_cnt  <= hold_n;
         gnt       <= gnt_n;
         gnt_id    <= id_n;
         gnt_valid <= valid_n;
         timeout   <= tmo_n;
      end
   end

endmodule

// File: tb/tb_arb4_rr.sv
// tb_arb4_rr: scenario bench for arb4_rr built with HOLD_MAX=4.
// Expected outputs are queued per driven cycle and compared after the edge.
module tb_arb4_rr;

   logic       clk;
   logic       rst;
   logic       en;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   logic [7:0] obs;
   logic [7:0] sb[$];
   int         checks;
   int         errors;

   typedef struct packed {
      logic [3:0] r;
      logic       e;
      logic       d;
      logic [7:0] x;
   } row_t;

   arb4_rr #(.HOLD_MAX(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   assign obs = {gnt, gnt_id, gnt_valid, timeout};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected value when agent id holds the grant.
   function automatic logic [7:0] g(input int id);
      logic [3:0] oh;
      oh = 4'b0001 << id;
      return {oh, 2'(id), 1'b1, 1'b0};
   endfunction

   // Expected value with no grant; t is the timeout bit.
   function automatic logic [7:0] idl(input logic t);
      return {4'b0000, 2'b00, 1'b0, t};
   endfunction

   function automatic row_t R(input logic [3:0] r, input logic e,
                              input logic d, input logic [7:0] x);
      row_t v;
      v.r = r;
      v.e = e;
      v.d = d;
      v.x = x;
      return v;
   endfunction

   task automatic apply_reset();
      rst  = 1'b1;
      req  = 4'b0000;
      en   = 1'b0;
      done = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] x;
      rst  = 1'b1;
      en   = 1'b1;
      done = 1'b0;
      req  = 4'b1111;
      for (int i = 0; i < 2; i++) begin
         sb.push_back(idl(1'b0));
         @(posedge clk);
         #1;
         x = sb.pop_front();
         checks++;
         if (obs !== x) begin
            errors++;
            $display("FAIL reset_hold[%0d]: got %b exp %b", i, obs, x);
         end
      end
      rst = 1'b0;
      req = 4'b0000;
      for (int i = 0; i < 2; i++) begin
         sb.push_back(idl(1'b0));
         @(posedge clk);
         #1;
         x = sb.pop_front();
         checks++;
         if (obs !== x) begin
            errors++;
            $display("FAIL reset_rel[%0d]: got %b exp %b", i, obs, x);
         end
      end
   endtask

   task automatic test_rotation();
      row_t       rows[$];
      logic [7:0] x;
      for (int a = 0; a < 4; a++) begin
         rows.push_back(R(4'b1111, 1'b1, 1'b0, g(a)));
         rows.push_back(R(4'b1111, 1'b1, 1'b0, g(a)));
         rows.push_back(R(4'b1111, 1'b1, 1'b1, idl(1'b0)));
      end
      rows.push_back(R(4'b1111, 1'b1, 1'b0, g(0)));
      rows.push_back(R(4'b1111, 1'b1, 1'b1, idl(1'b0)));
      for (int i = 0; i < rows.size(); i++) begin
         req  = rows[i].r;
         en   = rows[i].e;
         done = rows[i].d;
         sb.push_back(rows[i].x);
         @(posedge clk);
         #1;
         x = sb.pop_front();
         checks++;
         if (obs !== x) begin
            errors++;
            $display("FAIL rotation[%0d]: got %b exp %b", i, obs, x);
         end
      end
   endtask

   task automatic test_hold_limit();
      row_t       rows[$];
      logic [7:0] x;
      apply_reset();
      for (int k = 0; k < 4; k++)
         rows.push_back(R(4'b0011, 1'b1, 1'b0, g(0)));
      rows.push_back(R(4'b0011, 1'b1, 1'b0, idl(1'b1)));
      for (int k = 0; k < 4; k++)
         rows.push_back(R(4'b0011, 1'b1, 1'b0, g(1)));
      rows.push_back(R(4'b0011, 1'b1, 1'b0, idl(1'b1)));
      for (int k = 0; k < 4; k++)
         rows.push_back(R(4'b0011, 1'b1, 1'b0, g(0)));
      rows.push_back(R(4'b0011, 1'b1, 1'b1, idl(1'b0)));
      for (int i = 0; i < rows.size(); i++) begin
         req  = rows[i].r;
         en   = rows[i].e;
         done = rows[i].d;
         sb.push_back(rows[i].x);
         @(posedge clk);
         #1;
         x = sb.pop_front();
         checks++;
         if (obs !== x) begin
            errors++;
            $display("FAIL hold_limit[%0d]: got %b exp %b", i, obs, x);
         end
      end
   endtask

   task automatic test_drop_wrap();
      row_t       rows[$];
      logic [7:0] x;
      apply_reset();
      rows.push_back(R(4'b1000, 1'b1, 1'b0, g(3)));
      rows.push_back(R(4'b1110, 1'b1, 1'b0, g(3)));
      rows.push_back(R(4'b0000, 1'b1, 1'b0, idl(1'b0)));
      rows.push_back(R(4'b1001, 1'b1, 1'b0, g(0)));
      rows.push_back(R(4'b1001, 1'b1, 1'b0, g(0)));
      rows.push_back(R(4'b1000, 1'b1, 1'b0, idl(1'b0)));
      rows.push_back(R(4'b1001, 1'b1, 1'b0, g(3)));
      rows.push_back(R(4'b0001, 1'b1, 1'b0, idl(1'b0)));
      rows.push_back(R(4'b0011, 1'b1, 1'b0, g(0)));
      rows.push_back(R(4'b0011, 1'b1, 1'b1, idl(1'b0)));
      for (int i = 0; i < rows.size(); i++) begin
         req  = rows[i].r;
         en   = rows[i].e;
         done = rows[i].d;
         sb.push_back(rows[i].x);
         @(posedge clk);
         #1;
         x = sb.pop_front();
         checks++;
         if (obs !== x) begin
            errors++;
            $display("FAIL drop_wrap[%0d]: got %b exp %b", i, obs, x);
         end
      end
   endtask

   task automatic test_enable_done();
      row_t       rows[$];
      logic [7:0] x;
      apply_reset();
      rows.push_back(R(4'b0100, 1'b0, 1'b0, idl(1'b0)));
      rows.push_back(R(4'b0100, 1'b0, 1'b0, idl(1'b0)));
      rows.push_back(R(4'b0100, 1'b1, 1'b0, g(2)));
      rows.push_back(R(4'b0100, 1'b1, 1'b0, g(2)));
      rows.push_back(R(4'b0100, 1'b0, 1'b0, idl(1'b0)));
      rows.push_back(R(4'b0000, 1'b1, 1'b1, idl(1'b0)));
      rows.push_back(R(4'b0000, 1'b1, 1'b1, idl(1'b0)));
      // ptr is 3 now; agent 2 wins as the only requester.
      for (int k = 0; k < 4; k++)
         rows.push_back(R(4'b0100, 1'b1, 1'b0, g(2)));
      // en drop coincides with the limit: no timeout pulse.
      rows.push_back(R(4'b0100, 1'b0, 1'b0, idl(1'b0)));
      rows.push_back(R(4'b1111, 1'b0, 1'b0, idl(1'b0)));
      rows.push_back(R(4'b1111, 1'b0, 1'b1, idl(1'b0)));
      // ptr stayed at 3 while disabled.
      rows.push_back(R(4'b1111, 1'b1, 1'b0, g(3)));
      rows.push_back(R(4'b0111, 1'b1, 1'b0, idl(1'b0)));
      for (int i = 0; i < rows.size(); i++) begin
         req  = rows[i].r;
         en   = rows[i].e;
         done = rows[i].d;
         sb.push_back(rows[i].x);
         @(posedge clk);
         #1;
         x = sb.pop_front();
         checks++;
         if (obs !== x) begin
            errors++;
            $display("FAIL enable_done[%0d]: got %b exp %b", i, obs, x);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] x;
      apply_reset();
      en   = 1'b1;
      done = 1'b0;
      req  = 4'b0010;
      for (int i = 0; i < 2; i++) begin
         sb.push_back(g(1));
         @(posedge clk);
         #1;
         x = sb.pop_front();
         checks++;
         if (obs !== x) begin
            errors++;
            $display("FAIL async_pre[%0d]: got %b exp %b", i, obs, x);
         end
      end
      #2;
      rst = 1'b1;
      sb.push_back(idl(1'b0));
      #1;
      x = sb.pop_front();
      checks++;
      if (obs !== x) begin
         errors++;
         $display("FAIL async_clear: got %b exp %b", obs, x);
      end
      #1;
      rst = 1'b0;
      req = 4'b1111;
      sb.push_back(g(0));
      @(posedge clk);
      #1;
      x = sb.pop_front();
      checks++;
      if (obs !== x) begin
         errors++;
         $display("FAIL async_first: got %b exp %b", obs, x);
      end
      done = 1'b1;
      sb.push_back(idl(1'b0));
      @(posedge clk);
      #1;
      x = sb.pop_front();
      checks++;
      if (obs !== x) begin
         errors++;
         $display("FAIL async_done: got %b exp %b", obs, x);
      end
      done = 1'b0;
      sb.push_back(g(1));
      @(posedge clk);
      #1;
      x = sb.pop_front();
      checks++;
      if (obs !== x) begin
         errors++;
         $display("FAIL async_next: got %b exp %b", obs, x);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      en     = 1'b0;
      req    = 4'b0000;
      done   = 1'b0;
      test_reset();
      test_rotation();
      test_hold_limit();
      test_drop_wrap();
      test_enable_done();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
